// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared defaults and helpers for the fractional baud generator
package baud_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OSR_W_DEF  = 4;

    // Classic 16x oversampling (oversamples per bit minus 1).
    localparam logic [3:0] OSR_16X = 4'd15;

    // Oversample index of the mid-bit sample point.
    function automatic logic [15:0] half_idx(input logic [15:0] osr);
        return osr >> 1;
    endfunction

endpackage

// File: rtl/baud_gen_frac_if.sv
// rtl/baud_gen_frac_if.sv - control/config inputs and tick outputs of the baud generator
//   master: drives gen_en_i, restart_i, cfg_int_i, cfg_frac_i, cfg_osr_i
//   slave : drives os_tick_o, os_idx_o, bit_done_o, bit_half_done_o
interface baud_gen_frac_if
    import baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
);
    logic              gen_en_i;
    logic              restart_i;
    logic [DIV_W-1:0]  cfg_int_i;
    logic [FRAC_W-1:0] cfg_frac_i;
    logic [OSR_W-1:0]  cfg_osr_i;
    logic              os_tick_o;
    logic [OSR_W-1:0]  os_idx_o;
    logic              bit_done_o;
    logic              bit_half_done_o;

    modport master (
        output gen_en_i, restart_i, cfg_int_i, cfg_frac_i, cfg_osr_i,
        input  os_tick_o, os_idx_o, bit_done_o, bit_half_done_o
    );

    modport slave (
        input  gen_en_i, restart_i, cfg_int_i, cfg_frac_i, cfg_osr_i,
        output os_tick_o, os_idx_o, bit_done_o, bit_half_done_o
    );
endinterface

// File: rtl/baud_frac_acc.sv
// rtl/baud_frac_acc.sv - fractional phase accumulator with registered carry
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   clr_i          : clear accumulator and carry (start/restart/disable)
//   adv_i          : add frac_i once (end of an oversample period)
//   frac_i         : fractional increment, 1/2^FRAC_W units
//   carry_q        : overflow of the last add; lengthens the next period by one cycle
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_q
);
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, frac_i};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (adv_i) begin
            {carry_q, acc_q} <= sum;
        end
    end
endmodule

// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud-rate generator with per-bit strobes
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   bus (slave)    : gen_en_i/restart_i control, cfg_int/frac/osr config,
//                    os_tick_o, os_idx_o, bit_done_o, bit_half_done_o
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OSR_W  = OSR_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    baud_gen_frac_if.slave   bus
);
    logic              run_q;
    // One bit wider than the divider: after a carry with sh_int at all-ones
    // the count must reach 2^DIV_W.
    logic [DIV_W:0]    cnt_q;
    logic [DIV_W-1:0]  sh_int_q;
    logic [FRAC_W-1:0] sh_frac_q;
    logic [OSR_W-1:0]  sh_osr_q;
    logic [OSR_W-1:0]  idx_q;
    logic              carry_q;

    logic              active;
    logic              load;
    logic              tick;
    logic              at_last;
    logic              at_half;
    logic [DIV_W:0]    end_v;
    logic [OSR_W-1:0]  half_v;

    // Outputs are masked in any disabled or realign cycle.
    assign active  = bus.gen_en_i & ~bus.restart_i;
    assign load    = bus.gen_en_i & (~run_q | bus.restart_i);
    assign end_v   = {1'b0, sh_int_q} + {{DIV_W{1'b0}}, carry_q};
    assign tick    = run_q & active & (cnt_q == end_v);
    assign half_v  = OSR_W'(half_idx(16'(sh_osr_q)));
    assign at_last = (idx_q == sh_osr_q);
    assign at_half = (idx_q == half_v);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !bus.gen_en_i) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_int_q  <= '0;
            sh_frac_q <= '0;
            sh_osr_q  <= '0;
        end else if (load) begin
            run_q     <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_int_q  <= bus.cfg_int_i;
            sh_frac_q <= bus.cfg_frac_i;
            sh_osr_q  <= bus.cfg_osr_i;
        end else if (run_q) begin
            if (tick) begin
                cnt_q <= '0;
                idx_q <= at_last ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    baud_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (load | ~bus.gen_en_i),
        .adv_i   (tick),
        .frac_i  (sh_frac_q),
        .carry_q (carry_q)
    );

    assign bus.os_tick_o       = tick;
    assign bus.bit_done_o      = tick & at_last;
    assign bus.bit_half_done_o = tick & at_half;
    assign bus.os_idx_o        = active ? idx_q : '0;
endmodule
